// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: shadows the EX/MEM/WB destination tags and
// derives stage enables, bubble flushes, operand forwarding and event counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [1:0]       id_rs1_sel,
  input  logic [1:0]       id_rs2_sel,
  input  logic             id_mem_wen,
  input  logic             id_rf_wen,
  input  logic [1:0]       id_wb_sel,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  localparam logic [1:0] RS1_RS1 = 2'd0;
  localparam logic [1:0] RS2_RS2 = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rf_wen;
    logic [1:0] wb_sel;
    logic       mem_wen;
  } dst_tag_t;

  typedef struct packed {
    dst_tag_t   dst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
  } ex_tag_t;

  ex_tag_t          ex_tag_reg, ex_tag_next;
  dst_tag_t         mem_tag_reg, mem_tag_next;
  dst_tag_t         wb_tag_reg, wb_tag_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

  logic id_rs1_used, id_rs2_used;
  logic frozen, load_use;
  logic stall_event, flush_event;
  logic wb_tag_unused;

  function automatic logic is_writer(dst_tag_t t);
    return t.valid && t.rf_wen && (t.rd != 5'd0);
  endfunction

  assign id_rs1_used = (id_rs1_sel == RS1_RS1);
  assign id_rs2_used = (id_rs2_sel == RS2_RS2) || id_mem_wen;

  // A store or load stuck in MEM holds the whole pipe until memory answers.
  assign frozen = mem_tag_reg.valid
                  && (mem_tag_reg.mem_wen || (mem_tag_reg.wb_sel == WB_MEM))
                  && !dmem_ready;

  assign load_use = id_valid && is_writer(ex_tag_reg.dst)
                    && (ex_tag_reg.dst.wb_sel == WB_MEM)
                    && ((id_rs1_used && (ex_tag_reg.dst.rd == id_rs1_addr))
                     || (id_rs2_used && (ex_tag_reg.dst.rd == id_rs2_addr)));

  // WB only ever supplies rd for forwarding; its load/store flags are carried along.
  assign wb_tag_unused = ^{wb_tag_reg.wb_sel, wb_tag_reg.mem_wen};

  logic [4:0] ex_src      [2];
  logic       ex_src_used [2];
  logic [1:0] fwd_sel     [2];

  assign ex_src[0]      = ex_tag_reg.rs1;
  assign ex_src[1]      = ex_tag_reg.rs2;
  assign ex_src_used[0] = ex_tag_reg.rs1_used;
  assign ex_src_used[1] = ex_tag_reg.rs2_used;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
          (!ex_tag_reg.dst.valid || !ex_src_used[gi])                  ? FWD_RF  :
          (is_writer(mem_tag_reg) && (mem_tag_reg.rd == ex_src[gi]))   ? FWD_MEM :
          (is_writer(wb_tag_reg)  && (wb_tag_reg.rd  == ex_src[gi]))   ? FWD_WB  :
                                                                          FWD_RF;
    end
  endgenerate

  // Control priority: reset > freeze > redirect > load-use.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    fwd_rs1_sel = fwd_sel[0];
    fwd_rs2_sel = fwd_sel[1];
    stall_event = 1'b0;
    flush_event = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      fwd_rs1_sel = FWD_RF;
      fwd_rs2_sel = FWD_RF;
    end else if (frozen) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      stall_event = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      flush_event = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
      stall_event = 1'b1;
    end
  end

  always_comb begin
    ex_tag_next    = ex_tag_reg;
    mem_tag_next   = mem_tag_reg;
    wb_tag_next    = wb_tag_reg;
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (!frozen) begin
      wb_tag_next  = mem_tag_reg;
      mem_tag_next = ex_tag_reg.dst;
      if (idex_flush) begin
        ex_tag_next = '0;
      end else begin
        ex_tag_next.dst.valid   = id_valid;
        ex_tag_next.dst.rd      = id_rd_addr;
        ex_tag_next.dst.rf_wen  = id_rf_wen;
        ex_tag_next.dst.wb_sel  = id_wb_sel;
        ex_tag_next.dst.mem_wen = id_mem_wen;
        ex_tag_next.rs1         = id_rs1_addr;
        ex_tag_next.rs2         = id_rs2_addr;
        ex_tag_next.rs1_used    = id_rs1_used;
        ex_tag_next.rs2_used    = id_rs2_used;
      end
    end
    if (stall_event && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
    if (flush_event && (flush_cnt_reg != '1)) begin
      flush_cnt_next = flush_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag_reg    <= '0;
      mem_tag_reg   <= '0;
      wb_tag_reg    <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      ex_tag_reg    <= ex_tag_next;
      mem_tag_reg   <= mem_tag_next;
      wb_tag_reg    <= wb_tag_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a pipeline-shadow model predicts every cycle's
// controls and counters; a negedge monitor compares a 32-bit and a 4-bit counter build.
module tb_hazard_ctrl;

  localparam logic [1:0] RS1_RS1 = 2'd0, RS1_ZERO = 2'd2;
  localparam logic [1:0] RS2_RS2 = 2'd0, RS2_IMM  = 2'd1;
  localparam logic [1:0] WB_ALU  = 2'd0, WB_MEM   = 2'd1;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] rs1_sel, rs2_sel;
    logic       mem_wen, rf_wen;
    logic [1:0] wb_sel;
  } id_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd, rs1, rs2;
    logic       rf_wen, mem_wen, u1, u2;
    logic [1:0] wb_sel;
  } mtag_t;

  typedef struct {
    logic [10:0] ctrl;
    bit          cnt_known;
    longint      stall, flush, stall4, flush4;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_mem_wen, id_rf_wen, ex_redirect, dmem_ready;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [1:0] id_rs1_sel, id_rs2_sel, id_wb_sel;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ff, a_xf;
  logic [1:0]  a_f1, a_f2;
  logic [31:0] a_stall, a_flush;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ff, b_xf;
  logic [1:0]  b_f1, b_f2;
  logic [3:0]  b_stall, b_flush;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_sel(id_rs1_sel), .id_rs2_sel(id_rs2_sel), .id_mem_wen(id_mem_wen),
    .id_rf_wen(id_rf_wen), .id_wb_sel(id_wb_sel), .ex_redirect(ex_redirect),
    .dmem_ready(dmem_ready), .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex),
    .exmem_en(a_exmem), .memwb_en(a_memwb), .ifid_flush(a_ff), .idex_flush(a_xf),
    .fwd_rs1_sel(a_f1), .fwd_rs2_sel(a_f2),
    .perf_stall_cnt(a_stall), .perf_flush_cnt(a_flush)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_sel(id_rs1_sel), .id_rs2_sel(id_rs2_sel), .id_mem_wen(id_mem_wen),
    .id_rf_wen(id_rf_wen), .id_wb_sel(id_wb_sel), .ex_redirect(ex_redirect),
    .dmem_ready(dmem_ready), .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex),
    .exmem_en(b_exmem), .memwb_en(b_memwb), .ifid_flush(b_ff), .idex_flush(b_xf),
    .fwd_rs1_sel(b_f1), .fwd_rs2_sel(b_f2),
    .perf_stall_cnt(b_stall), .perf_flush_cnt(b_flush)
  );

  int     checks = 0;
  int     failures = 0;
  exp_t   exp_q[$];
  mtag_t  pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
  longint m_stall = 0, m_flush = 0, m_stall4 = 0, m_flush4 = 0;
  bit     m_known = 1'b0;

  function automatic id_t f_nop();
    id_t i = '0;
    i.rs1_sel = RS1_ZERO;
    i.rs2_sel = RS2_IMM;
    return i;
  endfunction

  function automatic id_t f_op(logic [4:0] rd, logic [4:0] a, logic [4:0] b,
                               bit use_b, bit is_load, bit is_store);
    id_t i;
    i.valid   = 1'b1;
    i.rs1     = a;
    i.rs2     = b;
    i.rd      = rd;
    i.rs1_sel = RS1_RS1;
    i.rs2_sel = use_b ? RS2_RS2 : RS2_IMM;
    i.mem_wen = is_store;
    i.rf_wen  = !is_store;
    i.wb_sel  = is_load ? WB_MEM : WB_ALU;
    return i;
  endfunction

  function automatic bit writer(mtag_t t);
    return t.valid && t.rf_wen && (t.rd != 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, want);
    end
  endtask

  // One clock of stimulus: drive, predict from the shadow pipeline, then advance it.
  task automatic cyc(input bit r, input id_t id, input bit redir, input bit ready);
    exp_t        e;
    bit          frz, lu, u1, u2;
    logic [4:0]  en;
    logic [1:0]  fl;
    logic [1:0]  f [2];
    logic [4:0]  src [2];
    bit          used [2];
    mtag_t       nt;
    @(posedge clk);
    #1;
    rst = r; ex_redirect = redir; dmem_ready = ready;
    id_valid = id.valid; id_rs1_addr = id.rs1; id_rs2_addr = id.rs2; id_rd_addr = id.rd;
    id_rs1_sel = id.rs1_sel; id_rs2_sel = id.rs2_sel; id_mem_wen = id.mem_wen;
    id_rf_wen = id.rf_wen; id_wb_sel = id.wb_sel;

    u1  = (id.rs1_sel == RS1_RS1);
    u2  = (id.rs2_sel == RS2_RS2) || id.mem_wen;
    frz = pipe[1].valid && (pipe[1].mem_wen || pipe[1].wb_sel == WB_MEM) && !ready;
    lu  = id.valid && writer(pipe[0]) && (pipe[0].wb_sel == WB_MEM)
          && ((u1 && pipe[0].rd == id.rs1) || (u2 && pipe[0].rd == id.rs2));

    src[0] = pipe[0].rs1; src[1] = pipe[0].rs2;
    used[0] = pipe[0].u1; used[1] = pipe[0].u2;
    for (int s = 0; s < 2; s++) begin
      f[s] = 2'd0;
      if (pipe[0].valid && used[s] && !r) begin
        // The nearest younger writer wins; stage distance equals the select code.
        for (int j = 2; j >= 1; j--)
          if (writer(pipe[j]) && pipe[j].rd == src[s]) f[s] = 2'(j);
      end
    end

    e.cnt_known = m_known;
    e.stall = m_stall; e.flush = m_flush; e.stall4 = m_stall4; e.flush4 = m_flush4;

    if (r) begin
      en = 5'b00000; fl = 2'b11;
    end else if (frz) begin
      en = 5'b00000; fl = 2'b00;
      m_stall++; if (m_stall4 < 15) m_stall4++;
    end else if (redir) begin
      en = 5'b11111; fl = 2'b11;
      m_flush++; if (m_flush4 < 15) m_flush4++;
    end else if (lu) begin
      en = 5'b00111; fl = 2'b01;
      m_stall++; if (m_stall4 < 15) m_stall4++;
    end else begin
      en = 5'b11111; fl = 2'b00;
    end
    e.ctrl = {en, fl, f[0], f[1]};
    exp_q.push_back(e);

    if (r) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
      m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
      m_known = 1'b1;
    end else if (!frz) begin
      nt = '0;
      if (!(redir || lu)) begin
        nt.valid = id.valid; nt.rd = id.rd; nt.rs1 = id.rs1; nt.rs2 = id.rs2;
        nt.rf_wen = id.rf_wen; nt.mem_wen = id.mem_wen; nt.wb_sel = id.wb_sel;
        nt.u1 = u1; nt.u2 = u2;
      end
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = nt;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctrl32", {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ff, a_xf, a_f1, a_f2}, 64'(e.ctrl));
      check("ctrl4",  {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ff, b_xf, b_f1, b_f2}, 64'(e.ctrl));
      if (e.cnt_known) begin
        check("stall_cnt32", 64'(a_stall), e.stall);
        check("flush_cnt32", 64'(a_flush), e.flush);
        check("stall_cnt4",  64'(b_stall), e.stall4);
        check("flush_cnt4",  64'(b_flush), e.flush4);
      end
    end
  end

  initial begin
    id_t nop;
    id_t rid;
    nop = f_nop();
    rst = 1'b1; ex_redirect = 1'b0; dmem_ready = 1'b1;
    {id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_sel, id_rs2_sel,
     id_mem_wen, id_rf_wen, id_wb_sel} = '0;

    // Reset then idle
    cyc(1, nop, 0, 1); cyc(1, nop, 0, 1); cyc(0, nop, 0, 1); cyc(0, nop, 0, 1);

    // Load-use: LW x5 then ADD x6,x5,x1 (held in ID across the stall), then forward from WB
    cyc(0, f_op(5, 1, 0, 0, 1, 0), 0, 1);
    cyc(0, f_op(6, 5, 1, 1, 0, 0), 0, 1);
    cyc(0, f_op(6, 5, 1, 1, 0, 0), 0, 1);
    cyc(0, nop, 0, 1); cyc(0, nop, 0, 1); cyc(0, nop, 0, 1);

    // Forward priority, then the same with rd = x0
    for (int k = 0; k < 2; k++) begin
      logic [4:0] r3;
      r3 = (k == 0) ? 5'd3 : 5'd0;
      cyc(0, f_op(r3, 1, 0, 0, 0, 0), 0, 1);
      cyc(0, f_op(r3, 2, 0, 0, 0, 0), 0, 1);
      cyc(0, f_op(4, r3, r3, 1, 0, 0), 0, 1);
      cyc(0, nop, 0, 1); cyc(0, nop, 0, 1); cyc(0, nop, 0, 1);
    end

    // Redirect overrides a simultaneous load-use
    cyc(0, f_op(7, 1, 0, 0, 1, 0), 0, 1);
    cyc(0, f_op(8, 7, 7, 1, 0, 0), 1, 1);
    cyc(0, nop, 0, 1); cyc(0, nop, 0, 1);

    // Store in MEM waiting three cycles with a pending redirect
    cyc(0, f_op(0, 1, 2, 1, 0, 1), 0, 1);
    cyc(0, nop, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, nop, 1, 0);
    cyc(0, nop, 1, 1);
    cyc(0, nop, 0, 1); cyc(0, nop, 0, 1);

    // Reset in the middle of a freeze
    cyc(0, f_op(9, 1, 0, 0, 1, 0), 0, 1);
    cyc(0, nop, 0, 1);
    cyc(0, nop, 0, 0);
    cyc(1, nop, 0, 0);
    cyc(0, nop, 0, 0); cyc(0, nop, 0, 1);

    // Twenty load-use stalls: the 4-bit counter must stick at 15
    for (int k = 0; k < 20; k++) begin
      cyc(0, f_op(5, 1, 0, 0, 1, 0), 0, 1);
      cyc(0, f_op(6, 5, 0, 1, 0, 0), 0, 1);
      cyc(0, f_op(6, 5, 0, 1, 0, 0), 0, 1);
    end

    // Randomized traffic over a small register set to provoke hazards
    for (int k = 0; k < 2000; k++) begin
      rid.valid   = ($urandom_range(0, 7) != 0);
      rid.rs1     = 5'($urandom_range(0, 3));
      rid.rs2     = 5'($urandom_range(0, 3));
      rid.rd      = 5'($urandom_range(0, 3));
      rid.rs1_sel = 2'($urandom_range(0, 2));
      rid.rs2_sel = 2'($urandom_range(0, 2));
      rid.mem_wen = ($urandom_range(0, 5) == 0);
      rid.rf_wen  = ($urandom_range(0, 3) != 0);
      rid.wb_sel  = 2'($urandom_range(0, 2));
      cyc(($urandom_range(0, 99) == 0), rid, ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 7));
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB). Takes the decoded control fields of the instruction in ID, tracks shadow tags of the instructions in EX, MEM and WB, and drives stage enables, flushes and EX operand forwarding selects. It resolves three conditions: load-use stalls, taken branch/jump redirects, and data-memory wait states. It also keeps saturating stall and flush counters.

## Interface
- CNT_W, 32, width of the performance counters
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  decoded register addresses
- id_rs1_sel, id_rs2_sel  in  2 each  operand selects, `RS1_*`/`RS2_*` encodings
- id_mem_wen  in  1  store flag
- id_rf_wen  in  1  register write-back enable
- id_wb_sel  in  2  write-back source, `WB_*` encodings
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush  out  1 each  load a bubble into IF/ID or ID/EX
- fwd_rs1_sel, fwd_rs2_sel  out  2 each  EX operand source: 00 register file, 01 EX/MEM result, 10 MEM/WB write-back data
- perf_stall_cnt, perf_flush_cnt  out  CNT_W each  event counters

## Operation
- **Register use:**
  - ID rs1 is used iff id_rs1_sel==`RS1_RS1`.
  - ID rs2 is used iff id_rs2_sel==`RS2_RS2` or id_mem_wen.
  - A writer is a tag with valid, rf_wen and rd!=0. x0 never matches.
- **Shadow tags:** EX, MEM and WB tags hold {valid, rd, rf_wen, wb_sel, mem_wen}. The EX tag additionally holds rs1/rs2 address and used flags.
- **Tag advance** (only when not frozen): WB<=MEM, MEM<=EX. EX<= bubble (valid=0) if idex_flush, else the ID fields with valid=id_valid.
- **Freeze:** MEM tag valid, (mem_wen or wb_sel==`WB_MEM`), and !dmem_ready.
  - All five enables = 0. Both flushes = 0. Tags hold.
- **Redirect** (not frozen, ex_redirect):
  - pc_en=1, ifid_flush=1, idex_flush=1.
  - ifid_en=idex_en=exmem_en=memwb_en=1.
- **Load-use** (not frozen, no redirect):
  - Condition: id_valid, EX tag is a writer with wb_sel==`WB_MEM`, and its rd equals a used ID source.
  - pc_en=0, ifid_en=0, idex_flush=1. idex_en, exmem_en and memwb_en = 1.
- **Otherwise:** all enables 1, flushes 0.
- **Priority:** freeze > redirect > load-use.
- **Forwarding,** per EX source, only if the EX tag is valid and that source is used:
  - 01 if the MEM tag is a writer with matching rd.
  - else 10 if the WB tag is a writer with matching rd.
  - else 00.
  - MEM wins over WB. Unused sources and invalid EX give 00. Load-use stalling guarantees a MEM-stage load never needs forwarding.
- **Counters:**
  - perf_stall_cnt increments on each cycle that is frozen or load-use stalled.
  - perf_flush_cnt increments on each redirect cycle.
  - Both saturate at all-ones.

## Timing
- All outputs except the counters are combinational from the tags and the current inputs. Tags and counters update on the rising clk edge.
- **Reset:** while rst=1, outputs are forced:
  - all enables 0, ifid_flush=idex_flush=1, fwd selects 00.
  - The next edge clears all tags to invalid and both counters to 0.
- **First cycle after reset** with id_valid=0, ex_redirect=0: all enables 1, flushes 0, fwd 00.
- **Stall durations:**
  - Load-use stall lasts exactly one cycle. After the bubble the load sits in MEM; the next cycle the consumer reaches EX with the load in WB, so forwarding gives 10.
  - Freeze lasts until the first cycle with dmem_ready=1. That cycle advances normally, and any pending redirect or load-use applies in that same cycle.
- **Redirect:** applies in the redirect cycle. The next cycle, the EX tag is invalid.
- **rst mid-freeze or mid-stall:** reset wins. No state survives.

## Test plan
- **Reset:** rst=1 two cycles, then idle -> during reset enables 0, flushes 1; after reset enables 1, flushes 0, counters 0.
- **Load-use:** LW x5 (EX) with ADD x6,x5,x1 in ID -> one cycle pc_en=0, ifid_en=0, idex_flush=1. Next cycle no stall. Two cycles after the stall cycle, ADD in EX gets fwd_rs1_sel=10. perf_stall_cnt=1.
- **Forward priority:** ADDI x3 in MEM, ADDI x3 in WB, ADD x4,x3,x3 in EX -> fwd_rs1_sel=fwd_rs2_sel=01. Same sequence with rd=x0 -> both 00.
- **Redirect:** ex_redirect=1 with a load-use condition also present -> ifid_flush=idex_flush=1, pc_en=1. perf_flush_cnt+1; perf_stall_cnt unchanged.
- **Memory wait:** SW in MEM with dmem_ready=0 for 3 cycles, with ex_redirect=1 held -> all enables 0 and flushes 0 for 3 cycles. On the 4th cycle (ready=1), the redirect flush occurs. perf_stall_cnt=3.
- **Saturation:** CNT_W=4, 20 load-use stall cycles -> perf_stall_cnt holds at 15.
